cla_pipe_adder: RTL

//   Parametrised, pipelined add/subtract unit built from 4-bit carry-lookahead groups.

---
 rtl/cla_pipe_adder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract unit: one slice of 4*GROUPS_PER_STAGE bits resolved per stage with 4-bit CLA groups.
// Latency: STAGES cycles from input transfer to output transfer at full throughput (1 beat/cycle).
// Backpressure: bubble-collapsing valid/ready; in_ready is combinational from out_ready through the stage valids.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand stream handshake (a, b, c_in, sub)
//   out_valid/out_ready     result stream handshake (sum, c_out, ovf)
//   sub=1 computes a-b as a+~b+1 (c_in ignored); c_out=1 then means no borrow
module cla_pipe_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int SW     = 4 * GROUPS_PER_STAGE;
    localparam int STAGES = WIDTH / SW;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % (4 * GROUPS_PER_STAGE)) != 0 || WIDTH < 4) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*GROUPS_PER_STAGE and at least 4");
    end

    // Resolve one slice. Each 4-bit group uses full lookahead from its own carry-in;
    // groups inside a slice chain through the group generate/propagate terms.
    // Returns {carry_out_of_slice, carry_into_slice_msb, slice_sum}.
    function automatic logic [SW+1:0] cla_slice(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          cin
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] s;
        logic [SW:0]   c;
        logic          gg;
        logic          pp;
        int            bi;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < GROUPS_PER_STAGE; k++) begin
            bi = 4 * k;
            c[bi+1] = g[bi] | (p[bi] & c[bi]);
            c[bi+2] = g[bi+1] | (p[bi+1] & g[bi]) | (p[bi+1] & p[bi] & c[bi]);
            c[bi+3] = g[bi+2] | (p[bi+2] & g[bi+1]) | (p[bi+2] & p[bi+1] & g[bi])
                    | (p[bi+2] & p[bi+1] & p[bi] & c[bi]);
            gg = g[bi+3] | (p[bi+3] & g[bi+2]) | (p[bi+3] & p[bi+2] & g[bi+1])
               | (p[bi+3] & p[bi+2] & p[bi+1] & g[bi]);
            pp = &p[bi +: 4];
            c[bi+4] = gg | (pp & c[bi]);
        end
        s = p ^ c[SW-1:0];
        return {c[SW], c[SW-1], s};
    endfunction

    // Per-stage state. b is stored already conditioned for subtraction, so the
    // sub flag itself need not travel down the pipe.
    logic [STAGES-1:0] v_q,     v_d;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_q, carry_d;
    logic              ovf_q,   ovf_d;

    // What each stage would load: the external beat for stage 0, the previous stage otherwise.
    logic [STAGES-1:0] up_vld;
    logic [STAGES-1:0] up_c;
    logic [WIDTH-1:0]  up_a    [STAGES];
    logic [WIDTH-1:0]  up_b    [STAGES];
    logic [WIDTH-1:0]  up_sum  [STAGES];

    logic [STAGES-1:0] load;

    // A stage loads when it is empty or its contents move on this edge;
    // scanning from the output back lets a bubble anywhere be filled at once.
    always_comb begin
        logic free_below;
        free_below = out_ready;
        load       = '0;
        for (int s = LAST; s >= 0; s--) begin
            load[s]    = !v_q[s] | free_below;
            free_below = load[s];
        end
        in_ready = rst_n & load[0];
    end

    always_comb begin
        logic [SW+1:0] res;
        up_vld[0] = in_valid & in_ready;
        up_a[0]   = a;
        up_b[0]   = b ^ {WIDTH{sub}};
        up_c[0]   = sub | c_in;
        up_sum[0] = '0;
        for (int s = 1; s < STAGES; s++) begin
            up_vld[s] = v_q[s-1];
            up_a[s]   = a_q[s-1];
            up_b[s]   = b_q[s-1];
            up_c[s]   = carry_q[s-1];
            up_sum[s] = sum_q[s-1];
        end

        ovf_d = ovf_q;
        for (int s = 0; s < STAGES; s++) begin
            res        = cla_slice(up_a[s][s*SW +: SW], up_b[s][s*SW +: SW], up_c[s]);
            v_d[s]     = load[s] ? up_vld[s] : v_q[s];
            a_d[s]     = a_q[s];
            b_d[s]     = b_q[s];
            sum_d[s]   = sum_q[s];
            carry_d[s] = carry_q[s];
            // Data only changes on a real load, so a stalled output stays stable.
            if (load[s] && up_vld[s]) begin
                a_d[s]                = up_a[s];
                b_d[s]                = up_b[s];
                sum_d[s]              = up_sum[s];
                sum_d[s][s*SW +: SW]  = res[SW-1:0];
                carry_d[s]            = res[SW+1];
                if (s == LAST) begin
                    ovf_d = res[SW+1] ^ res[SW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            v_q     <= v_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                sum_q[s] <= sum_d[s];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = sum_q[LAST];
    assign c_out     = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule
